// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the 50 MHz system reset and, after a stagger, the 200 MHz core reset.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES = 4,
  parameter int LOCK_TIMEOUT     = 1000,
  parameter int STABLE_CYCLES    = 16,
  parameter int STAGGER_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       clear_err,
  output logic       pll_rst,
  output logic       rst_sys_n,
  output logic       rst_core_n,
  output logic       ready,
  output logic [7:0] lock_loss_cnt,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_REL_SYS,
    S_RUN
  } state_t;

  localparam logic [15:0] RST_LAST     = 16'(RST_PULSE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] STAGGER_LAST = 16'(STAGGER_CYCLES - 1);

  state_t      state;
  logic [15:0] timer;
  logic        lock_meta;
  logic        lock_s;
  logic        loss_event;
  logic        timeout_event;

  always_comb begin
    loss_event    = ((state == S_REL_SYS) || (state == S_RUN)) && !lock_s;
    timeout_event = (state == S_WAIT_LOCK) && !lock_s && (timer == TIMEOUT_LAST);
  end

  // The single shared timer restarts at zero on every state change.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_PLL_RST;
      timer         <= '0;
      lock_meta     <= 1'b0;
      lock_s        <= 1'b0;
      pll_rst       <= 1'b1;
      rst_sys_n     <= 1'b0;
      rst_core_n    <= 1'b0;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
      timeout_err   <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;

      if (timeout_event)
        timeout_err <= 1'b1;
      else if (clear_err)
        timeout_err <= 1'b0;

      // A loss arriving together with clear_err leaves a count of one.
      if (loss_event)
        lock_loss_cnt <= clear_err ? 8'd1 :
                         (lock_loss_cnt == 8'hFF) ? lock_loss_cnt : lock_loss_cnt + 8'd1;
      else if (clear_err)
        lock_loss_cnt <= '0;

      case (state)
        S_PLL_RST: begin
          if (timer == RST_LAST) begin
            state   <= S_WAIT_LOCK;
            timer   <= '0;
            pll_rst <= 1'b0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state <= S_STABLE;
            timer <= '0;
          end else if (timeout_event) begin
            state   <= S_PLL_RST;
            timer   <= '0;
            pll_rst <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state <= S_WAIT_LOCK;
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            state     <= S_REL_SYS;
            timer     <= '0;
            rst_sys_n <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_REL_SYS: begin
          if (!lock_s) begin
            state      <= S_PLL_RST;
            timer      <= '0;
            pll_rst    <= 1'b1;
            rst_sys_n  <= 1'b0;
            rst_core_n <= 1'b0;
            ready      <= 1'b0;
          end else if (timer == STAGGER_LAST) begin
            state      <= S_RUN;
            timer      <= '0;
            rst_core_n <= 1'b1;
            ready      <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state      <= S_PLL_RST;
            timer      <= '0;
            pll_rst    <= 1'b1;
            rst_sys_n  <= 1'b0;
            rst_core_n <= 1'b0;
            ready      <= 1'b0;
          end
        end
        default: begin
          state      <= S_PLL_RST;
          timer      <= '0;
          pll_rst    <= 1'b1;
          rst_sys_n  <= 1'b0;
          rst_core_n <= 1'b0;
          ready      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RST_PULSE_CYCLES, default 4, meaning: cycles pll_rst is held high per PLL reset request.
REQ-002 Parameter LOCK_TIMEOUT, default 1000, meaning: cycles allowed in WAIT_LOCK before a timeout.
REQ-003 Parameter STABLE_CYCLES, default 16, meaning: consecutive synchronized-locked samples required before release.
REQ-004 Parameter STAGGER_CYCLES, default 8, meaning: cycles between rst_sys_n release and rst_core_n release.
REQ-005 clk  in  1  free-running 50 MHz reference clock (same source as the PLL refclk, never a PLL output).
REQ-006 reset_n  in  1  synchronous, active-low block reset.
REQ-007 pll_locked  in  1  PLL locked indication, asynchronous to clk.
REQ-008 clear_err  in  1  synchronous clear of timeout_err and lock_loss_cnt.
REQ-009 pll_rst  out  1  active-high reset to the PLL rst input.
REQ-010 rst_sys_n  out  1  active-low reset for 50 MHz system logic.
REQ-011 rst_core_n  out  1  active-low reset for 200 MHz core logic (consumer resynchronizes).
REQ-012 ready  out  1  high when both domain resets are released and lock is stable.
REQ-013 lock_loss_cnt  out  8  saturating count of lock losses after release.
REQ-014 timeout_err  out  1  sticky flag: lock not achieved within LOCK_TIMEOUT.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer (lock_s); no other logic SHALL use pll_locked directly.
REQ-016 All outputs SHALL be registered; one shared 16-bit timer SHALL serve all states; parameters SHALL each be >=1 and <=65535.
REQ-017 States: PLL_RST, WAIT_LOCK, STABLE, REL_SYS, RUN.
REQ-018 PLL_RST: pll_rst=1, rst_sys_n=0, rst_core_n=0, ready=0; after exactly RST_PULSE_CYCLES cycles -> WAIT_LOCK with pll_rst=0, timer cleared.
REQ-019 WAIT_LOCK: lock_s=1 -> STABLE; timer reaching LOCK_TIMEOUT with lock_s=0 -> set timeout_err, -> PLL_RST.
REQ-020 STABLE: counts consecutive lock_s=1 samples; any lock_s=0 -> WAIT_LOCK with timer cleared, no lock_loss_cnt increment; after STABLE_CYCLES consecutive highs -> REL_SYS with rst_sys_n=1 on the next cycle.
REQ-021 REL_SYS: rst_sys_n=1; after STAGGER_CYCLES cycles -> RUN; rst_core_n and ready SHALL rise in the same cycle.
REQ-022 RUN: hold rst_sys_n=1, rst_core_n=1, ready=1 while lock_s=1.
REQ-023 lock_s=0 in REL_SYS or RUN: next cycle rst_sys_n=0, rst_core_n=0, ready=0, lock_loss_cnt+1, -> PLL_RST.
REQ-024 lock_loss_cnt SHALL saturate at 255 and never wrap.
REQ-025 clear_err=1 SHALL clear timeout_err and lock_loss_cnt on the next cycle; a set/increment event in the same cycle SHALL win (timeout_err=1, or lock_loss_cnt=1).
REQ-026 clear_err SHALL not affect state, timer, or reset outputs.
REQ-027 rst_core_n SHALL never be 1 while rst_sys_n is 0; ready SHALL equal rst_core_n.

Reset
REQ-028 reset_n=0 sampled on a rising clk edge SHALL, on that edge, force state=PLL_RST, timer=0, pll_rst=1, rst_sys_n=0, rst_core_n=0, ready=0, lock_loss_cnt=0, timeout_err=0, synchronizer flops=0.
REQ-029 reset_n asserted mid-operation (any state) SHALL behave identically to power-on reset; the PLL_RST pulse count restarts at the first cycle with reset_n=1.

Verification
REQ-030 Defaults, pll_locked=1 from start, reset_n released at cycle 0 -> pll_rst high cycles 0-3; rst_sys_n rises after 2-cycle sync + 16 stable cycles; rst_core_n and ready rise exactly 8 cycles after rst_sys_n; lock_loss_cnt=0.
REQ-031 In RUN, drop pll_locked 1 cycle -> resets and ready fall 3 cycles later (2 sync + 1), lock_loss_cnt=1, pll_rst pulses 4 cycles, full sequence repeats.
REQ-032 pll_locked=0 permanently -> timeout_err=1 after 4+1000 cycles, pll_rst re-pulses every 1004+ cycles, rst_sys_n stays 0.
REQ-033 pll_locked glitches low at stable sample 10 of 16 -> return to WAIT_LOCK, lock_loss_cnt unchanged, rst_sys_n stays 0 until 16 fresh consecutive highs.
REQ-034 Force 256 lock losses -> lock_loss_cnt=255; clear_err pulse -> 0; clear_err coincident with a loss -> 1.
REQ-035 reset_n pulsed low during REL_SYS -> all outputs at reset values next edge; rst_core_n never high before rst_sys_n (checked by assertion throughout).
